// File: rtl/module_disp_mux_n.sv
// module_disp_mux_n: N-digit multiplexed seven-segment driver with hex decode, PWM dimming and
// frame-synchronous (tear-free) data update. Define DISP_LZB_EN for leading-zero blanking.

module disp_mux_digit (
    input  logic [3:0] nib,
    input  logic       dp_en,
    input  logic       dark,
    output logic [6:0] seg_on,
    output logic       dp_on,
    output logic       vis
);
    logic [6:0] pat_n;

    // table is {a..g} with 0 = segment on
    always_comb begin
        pat_n = 7'b1111111;
        case (nib)
            4'h0: pat_n = 7'b0000001;
            4'h1: pat_n = 7'b1001111;
            4'h2: pat_n = 7'b0010010;
            4'h3: pat_n = 7'b0000110;
            4'h4: pat_n = 7'b1001100;
            4'h5: pat_n = 7'b0100100;
            4'h6: pat_n = 7'b0100000;
            4'h7: pat_n = 7'b0001111;
            4'h8: pat_n = 7'b0000000;
            4'h9: pat_n = 7'b0000100;
            4'hA: pat_n = 7'b0001000;
            4'hB: pat_n = 7'b1100000;
            4'hC: pat_n = 7'b0110001;
            4'hD: pat_n = 7'b1000010;
            4'hE: pat_n = 7'b0110000;
            4'hF: pat_n = 7'b0111000;
            default: pat_n = 7'b1111111;
        endcase
    end

    assign seg_on = ~pat_n;
    assign vis    = ~dark;
    assign dp_on  = dp_en & ~dark;
endmodule

module module_disp_mux_n #(
    parameter int NUM_DIGITS = 4,
    parameter int DIVIDER    = 100000,
    parameter int BRIGHT_W   = 3,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIVIDER - 1);
    localparam logic [6:0]            SEG_POL = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{ACTIVE_LOW}};

    typedef struct packed {
        logic [NUM_DIGITS-1:0][3:0] data;
        logic [NUM_DIGITS-1:0]      dp;
        logic [NUM_DIGITS-1:0]      blank;
        logic [BRIGHT_W-1:0]        bright;
    } disp_set_t;

    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [BRIGHT_W-1:0] pwm_q, pwm_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    disp_set_t           pend_q, act_q, act_d, in_set;
    logic                tick, slot_end, frame_end;

    assign in_set.data   = data;
    assign in_set.dp     = dp;
    assign in_set.blank  = blank;
    assign in_set.bright = brightness;

    assign tick      = (pre_q == PRE_LAST);
    assign slot_end  = tick && (pwm_q == '1);
    assign frame_end = slot_end && (sel_q == SEL_LAST);

    // a load landing on the boundary tick bypasses the pending set
    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        pwm_d = tick ? pwm_q + 1'b1 : pwm_q;
        sel_d = sel_q;
        if (slot_end)
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        act_d = act_q;
        if (frame_end)
            act_d = load ? in_set : pend_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            pwm_q  <= '0;
            sel_q  <= '0;
            pend_q <= '0;
            act_q  <= '0;
        end else begin
            pre_q <= pre_d;
            pwm_q <= pwm_d;
            sel_q <= sel_d;
            act_q <= act_d;
            if (load)
                pend_q <= in_set;
        end
    end

    logic [NUM_DIGITS-1:0] lz_dark;
`ifdef DISP_LZB_EN
    logic zero_run;
    // digit i is a leading zero when it and every digit above it are zero; digit 0 always shows
    always_comb begin
        lz_dark  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run   = zero_run && (act_d.data[i] == 4'h0);
            lz_dark[i] = zero_run;
        end
    end
`else
    assign lz_dark = '0;
`endif

    logic [NUM_DIGITS-1:0][6:0] dig_seg;
    logic [NUM_DIGITS-1:0]      dig_dp, dig_vis;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        disp_mux_digit u_dig (
            .nib    (act_d.data[g]),
            .dp_en  (act_d.dp[g]),
            .dark   (act_d.blank[g] | lz_dark[g]),
            .seg_on (dig_seg[g]),
            .dp_on  (dig_dp[g]),
            .vis    (dig_vis[g])
        );
    end

    // outputs are registered from next state so frame_done aligns with digit 0 of the new set
    logic                  lit;
    logic [6:0]            seg_ah;
    logic                  dp_ah;
    logic [NUM_DIGITS-1:0] an_ah;

    always_comb begin
        lit    = dig_vis[sel_d] && (pwm_d <= act_d.bright);
        seg_ah = lit ? dig_seg[sel_d] : 7'b0;
        dp_ah  = lit & dig_dp[sel_d];
        an_ah  = '0;
        if (lit)
            an_ah[sel_d] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= SEG_POL;
            dp_out     <= ACTIVE_LOW;
            an         <= AN_POL;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_ah ^ SEG_POL;
            dp_out     <= dp_ah ^ ACTIVE_LOW;
            an         <= an_ah ^ AN_POL;
            frame_done <= frame_end;
        end
    end
endmodule

// File: tb/tb_module_disp_mux_n.sv
// Directed bench for module_disp_mux_n: 4 digits, DIVIDER=2, BRIGHT_W=2, active-low, 32-cycle frame.
module tb_module_disp_mux_n;
    logic        clk = 1'b0, rst = 1'b0, load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0, blank = '0;
    logic [1:0]  brightness = '0;
    logic [6:0]  seg;
    logic        dp_out, frame_done;
    logic [3:0]  an;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    module_disp_mux_n #(.NUM_DIGITS(4), .DIVIDER(2), .BRIGHT_W(2), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .data(data), .dp(dp), .blank(blank), .brightness(brightness),
        .load(load), .seg(seg), .dp_out(dp_out), .an(an), .frame_done(frame_done)
    );

    typedef struct {
        string           name;
        logic [15:0]     data;
        logic [3:0]      dp;
        logic [3:0]      blank;
        logic [1:0]      bright;
        logic [3:0][6:0] segs;     // {d3,d2,d1,d0}, active-low patterns
        logic [3:0]      lit;      // digits lit without leading-zero blanking
        logic [3:0]      lit_lzb;  // digits lit with leading-zero blanking
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [15:0] d, input logic [3:0] p,
                                input logic [3:0] b, input logic [1:0] br, input logic [27:0] s,
                                input logic [3:0] l, input logic [3:0] lz);
        vec_t v;
        v.name = nm; v.data = d; v.dp = p; v.blank = b; v.bright = br;
        v.segs = s; v.lit = l; v.lit_lzb = lz;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        data = v.data; dp = v.dp; blank = v.blank; brightness = v.bright;
    endtask

    task automatic wait_fd(input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!frame_done && n < 100);
        cmp({nm, " fd_seen"}, {31'b0, frame_done}, 32'd1);
    endtask

    // Starts on frame cycle 0 (sampled just after the edge); optional loads issued after cycles la/lb.
    task automatic check_frame(input vec_t v, input int la, input vec_t va, input int lb, input vec_t vb);
        logic [3:0]  litm;
        logic        on;
        logic [12:0] e;
        int          slot;
`ifdef DISP_LZB_EN
        litm = v.lit_lzb;
`else
        litm = v.lit;
`endif
        for (int c = 0; c < 32; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                load = 1'b0;
            end
            slot = c / 8;
            on   = litm[slot] && ((c % 8) < 2 * (v.bright + 1));
            e    = {c == 0, on ? ~(4'b0001 << slot) : 4'hF, ~(on & v.dp[slot]), on ? v.segs[slot] : 7'h7F};
            cmp($sformatf("%s c%0d {fd,an,dp,seg}", v.name, c), {19'b0, frame_done, an, dp_out, seg}, {19'b0, e});
            if (c == la) begin @(negedge clk); drive(va); load = 1'b1; end
            if (c == lb) begin @(negedge clk); drive(vb); load = 1'b1; end
        end
    endtask

    task automatic do_vector(input vec_t v);
        wait_fd({v.name, " pre"});
        @(negedge clk); drive(v); load = 1'b1;
        @(posedge clk); #1; load = 1'b0;
        wait_fd(v.name);
        check_frame(v, -1, v, -1, v);
    endtask

    task automatic release_and_check(input string nm, input vec_t vr);
        int n;
        @(negedge clk); rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!frame_done && n < 100);
        cmp({nm, " fd_latency"}, n, 32);
        check_frame(vr, -1, vr, -1, vr);
    endtask

    vec_t tbl[6];
    vec_t v_rst, v_1234, v_5678, v_9abc;

    initial begin
        v_rst  = mk("rst_zero", 16'h0000, 4'b0000, 4'b0000, 2'd0,
                    {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111, 4'b0001);
        tbl[0] = mk("hexA5F0", 16'hA5F0, 4'b0000, 4'b0000, 2'd3,
                    {7'b0001000, 7'b0100100, 7'b0111000, 7'b0000001}, 4'b1111, 4'b1111);
        tbl[1] = mk("pwm1234", 16'h1234, 4'b0000, 4'b0000, 2'd0,
                    {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1111, 4'b1111);
        tbl[2] = mk("blank6789", 16'h6789, 4'b0001, 4'b0100, 2'd1,
                    {7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100}, 4'b1011, 4'b1011);
        tbl[3] = mk("lz0040", 16'h0040, 4'b0000, 4'b0000, 2'd3,
                    {7'b0000001, 7'b0000001, 7'b1001100, 7'b0000001}, 4'b1111, 4'b0011);
        tbl[4] = mk("zero_dp", 16'h0000, 4'b1111, 4'b0000, 2'd2,
                    {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1111, 4'b0001);
        tbl[5] = mk("hexBCDE", 16'hBCDE, 4'b1010, 4'b0000, 2'd3,
                    {7'b1100000, 7'b0110001, 7'b1000010, 7'b0110000}, 4'b1111, 4'b1111);
        v_1234 = mk("ld1234", 16'h1234, 4'b0000, 4'b0000, 2'd3,
                    {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1111, 4'b1111);
        v_5678 = mk("tear5678", 16'h5678, 4'b0000, 4'b0000, 2'd3,
                    {7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000}, 4'b1111, 4'b1111);
        v_9abc = mk("bnd9ABC", 16'h9ABC, 4'b0000, 4'b0000, 2'd3,
                    {7'b0000100, 7'b0001000, 7'b1100000, 7'b0110001}, 4'b1111, 4'b1111);

        // reset acts before any clock edge
        #1 rst = 1'b1;
        #1 cmp("reset_async {fd,an,dp,seg}", {19'b0, frame_done, an, dp_out, seg}, {19'b0, 1'b0, 4'hF, 1'b1, 7'h7F});
        repeat (3) @(negedge clk);
        cmp("reset_held {fd,an,dp,seg}", {19'b0, frame_done, an, dp_out, seg}, {19'b0, 1'b0, 4'hF, 1'b1, 7'h7F});
        release_and_check("reset1", v_rst);

        for (int i = 0; i < 6; i++) do_vector(tbl[i]);

        // two loads inside one frame: that frame keeps the old set, the next shows only the last load
        wait_fd("tear_start");
        check_frame(tbl[5], 3, v_1234, 12, v_5678);
        wait_fd("tear_next");
        // load on the boundary tick shows in the frame that starts right after it
        check_frame(v_5678, 31, v_9abc, -1, v_9abc);
        @(posedge clk); #1; load = 1'b0;
        check_frame(v_9abc, -1, v_9abc, -1, v_9abc);

        // reset mid-frame while a digit is lit
        wait_fd("midrst");
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1 cmp("reset_mid_async {fd,an,dp,seg}", {19'b0, frame_done, an, dp_out, seg}, {19'b0, 1'b0, 4'hF, 1'b1, 7'h7F});
        repeat (2) @(negedge clk);
        release_and_check("reset2", v_rst);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
